// File: rtl/fifo_rd_fwft_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_fwft_pkg
// Shared definitions for the asynchronous FIFO pointer blocks: default word and
// address sizes, the read-side output FSM state type, and the binary/gray
// conversion helpers. The write-side pointer/full-flag block imports the same
// helpers, so both domains encode pointers identically.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_rd_fwft_pkg;

  localparam int unsigned FIFO_DATA_WIDTH_DFLT = 32'd8;
  localparam int unsigned FIFO_ADDR_WIDTH_DFLT = 32'd3;

  // Output register state: IDLE means DOUT is empty, HOLD means DOUT is valid.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } rd_state_e;

  // Binary to gray: adjacent values differ in exactly one bit.
  // Operates on 32 bits; callers zero-extend and cast the result to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 32'd1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  // Zero-extended inputs convert correctly because the upper zeros are neutral.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
// Combinational gray-to-binary converter of configurable width.
// Ports:
//   i_gray  input  WIDTH  gray-coded value
//   o_bin   output WIDTH  binary equivalent
// -----------------------------------------------------------------------------
module fifo_gray2bin
  import fifo_rd_fwft_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_bin = WIDTH'(gray2bin(32'(i_gray)));

endmodule

// File: rtl/fifo_rd_fwft.sv
// -----------------------------------------------------------------------------
// fifo_rd_fwft
// Read-domain pointer and first-word-fall-through output stage of an
// asynchronous FIFO. Produces the binary memory read address, the registered
// gray read pointer for the write-domain synchroniser, the EMPTY flag, and a
// registered output word with a valid/ready handshake.
//
// Optional feature macro: FIFO_RD_OCCUPANCY_EN adds RD_LEVEL, the number of
// unread words (memory plus the word held in DOUT).
//
// Ports:
//   R_CLK        input   1        read-domain clock
//   R_RST        input   1        asynchronous active-low reset
//   SYNC_WR_PTR  input   A+1      gray write pointer, synchronised to R_CLK
//   RD_DATA      input   D        memory data at RD_ADDR (combinational read)
//   R_READY      input   1        consumer takes DOUT this cycle
//   RD_ADDR      output  A        binary read address (registered)
//   RD_PTR       output  A+1      gray read pointer (registered)
//   EMPTY        output  1        no unread word in memory
//   DOUT         output  D        registered output word
//   RD_LEVEL     output  A+1      occupancy (only with FIFO_RD_OCCUPANCY_EN)
//   DOUT_VALID   output  1        DOUT holds a valid word
// -----------------------------------------------------------------------------
module fifo_rd_fwft
  import fifo_rd_fwft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = FIFO_DATA_WIDTH_DFLT,
  parameter int unsigned ADDRESS_WIDTH = FIFO_ADDR_WIDTH_DFLT
) (
  input  logic                     R_CLK,
  input  logic                     R_RST,
  input  logic [ADDRESS_WIDTH:0]   SYNC_WR_PTR,
  input  logic [DATA_WIDTH-1:0]    RD_DATA,
  input  logic                     R_READY,
  output logic [ADDRESS_WIDTH-1:0] RD_ADDR,
  output logic [ADDRESS_WIDTH:0]   RD_PTR,
  output logic                     EMPTY,
  output logic [DATA_WIDTH-1:0]    DOUT,
`ifdef FIFO_RD_OCCUPANCY_EN
  output logic [ADDRESS_WIDTH:0]   RD_LEVEL,
`endif
  output logic                     DOUT_VALID
);

  localparam int unsigned PW = ADDRESS_WIDTH + 32'd1;

  logic [PW-1:0]         r_bin;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_dout;
  rd_state_e             r_state;

  logic [PW-1:0]         w_bin_nxt;
  logic                  w_empty;
  logic                  w_pop;

  // Compare against the registered gray pointer, so a pop can never run past
  // the write pointer even if SYNC_WR_PTR moves in the same cycle.
  assign w_empty   = (r_rd_ptr == SYNC_WR_PTR);
  assign w_pop     = !w_empty && ((r_state == ST_IDLE) || R_READY);
  assign w_bin_nxt = r_bin + PW'(1);

  // Output FSM: tracks whether DOUT holds a word not yet taken by the consumer.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Without a pop, R_READY here implies EMPTY: the word leaves, none follows.
          if (!w_pop && R_READY) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pointer and data register: advance both pointers and capture the word on pop.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_bin    <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else if (w_pop) begin
      r_bin    <= w_bin_nxt;
      // Gray pointer is derived from the next binary value so it never lags.
      r_rd_ptr <= PW'(bin2gray(32'(w_bin_nxt)));
      r_dout   <= RD_DATA;
    end else begin
      r_bin    <= r_bin;
      r_rd_ptr <= r_rd_ptr;
      r_dout   <= r_dout;
    end
  end

  assign RD_ADDR    = r_bin[ADDRESS_WIDTH-1:0];
  assign RD_PTR     = r_rd_ptr;
  assign EMPTY      = w_empty;
  assign DOUT       = r_dout;
  assign DOUT_VALID = (r_state == ST_HOLD);

`ifdef FIFO_RD_OCCUPANCY_EN
  logic [PW-1:0] w_wr_bin;
  logic [PW-1:0] w_bin_after;
  logic          w_valid_after;
  logic [PW-1:0] r_level;

  fifo_gray2bin #(
    .WIDTH (PW)
  ) u_wr_gray2bin (
    .i_gray (SYNC_WR_PTR),
    .o_bin  (w_wr_bin)
  );

  // Level is computed from the post-edge pointer and valid so that it stays
  // consistent with RD_ADDR/DOUT_VALID in the same cycle.
  assign w_bin_after   = w_pop ? w_bin_nxt : r_bin;
  assign w_valid_after = w_pop || (DOUT_VALID && !R_READY);

  // Occupancy register: words still in memory plus the word held in DOUT.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_level <= '0;
    end else begin
      r_level <= (w_wr_bin - w_bin_after) + PW'(w_valid_after);
    end
  end

  assign RD_LEVEL = r_level;
`endif

endmodule
